// File: rtl/enigma_display_sequencer_if.sv
// Character stream into the display sequencer: valid/ready handshake carrying one ASCII code.
interface enigma_display_sequencer_if;
    logic [7:0] in_ascii;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_ascii, output in_valid, input  in_ready);
    modport slave  (input  in_ascii, input  in_valid, output in_ready);
endinterface

// File: rtl/enigma_display_sequencer.sv
// Buffers incoming characters in a small FIFO and scrolls them onto a seven-segment digit
// bank from the right, one step per dwell period.
module enigma_display_sequencer #(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned DWELL_CYCLES = 25000000
) (
    input  logic                                  clock,
    input  logic                                  reset,
    enigma_display_sequencer_if.slave             in_if,
    input  logic                                  clear,
    output logic [NUM_DIGITS*8-1:0]               digits_ascii,
    output logic                                  update,
    output logic                                  busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_count
);
    localparam int unsigned DIG_W   = NUM_DIGITS * 8;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned DWELL_W = $clog2(DWELL_CYCLES);

    localparam logic [7:0]  BLANK   = 8'h20;
    localparam logic [0:0]  ST_IDLE = 1'b0;
    localparam logic [0:0]  ST_HOLD = 1'b1;

    logic [0:0]         state_q,  state_d;
    logic [DWELL_W-1:0] dwell_q,  dwell_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic [DIG_W-1:0]   digits_q, digits_d;
    logic               update_q, update_d;
    logic               busy_q,   busy_d;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [7:0]         mem_d [FIFO_DEPTH];

    logic               full_c;
    logic               in_ready_c;
    logic               push_c;
    logic               pop_c;
    logic               is_lower_c;
    logic [7:0]         in_char_c;

    // Ready depends only on stored occupancy and clear, never on in_valid.
    assign full_c       = (count_q == CNT_W'(FIFO_DEPTH));
    assign in_ready_c   = !full_c && !clear;
    assign in_if.in_ready = in_ready_c;
    assign push_c       = in_if.in_valid && in_ready_c;

    assign is_lower_c   = (in_if.in_ascii >= 8'h61) && (in_if.in_ascii <= 8'h7A);
    assign in_char_c    = is_lower_c ? (in_if.in_ascii - 8'h20) : in_if.in_ascii;

    // Next-state, FIFO and digit-shift logic; clear overrides everything.
    always_comb begin
        state_d  = state_q;
        dwell_d  = dwell_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        digits_d = digits_q;
        mem_d    = mem_q;
        update_d = 1'b0;
        pop_c    = 1'b0;

        if (clear) begin
            state_d  = ST_IDLE;
            dwell_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            digits_d = {NUM_DIGITS{BLANK}};
            update_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (count_q != '0) begin
                        pop_c = 1'b1;
                        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
                            digits_d[k*8 +: 8] = digits_q[(k-1)*8 +: 8];
                        end
                        digits_d[7:0] = mem_q[rd_ptr_q];
                        rd_ptr_d      = rd_ptr_q + PTR_W'(1);
                        // Pop-to-pop spacing is DWELL_CYCLES: load cycle, countdown, IDLE cycle.
                        dwell_d       = DWELL_W'(DWELL_CYCLES - 2);
                        state_d       = ST_HOLD;
                        update_d      = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (dwell_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        dwell_d = dwell_q - DWELL_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (push_c) begin
                mem_d[wr_ptr_q] = in_char_c;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end

            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        busy_d = (count_d != '0) || (state_d == ST_HOLD);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            dwell_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            digits_q <= {NUM_DIGITS{BLANK}};
            update_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dwell_q  <= dwell_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            digits_q <= digits_d;
            update_q <= update_d;
            busy_q   <= busy_d;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign digits_ascii = digits_q;
    assign update       = update_q;
    assign busy         = busy_q;
    assign fifo_count   = count_q;

endmodule

// File: tb/tb_enigma_display_sequencer.sv
// Self-checking bench: table vectors, hand-written corner sequences and random traffic
// compared against a queue-based reference model.
module tb_enigma_display_sequencer;
    localparam int unsigned ND = 4;
    localparam int unsigned FD = 4;
    localparam int unsigned DW = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [31:0] digits_ascii;
    logic        update;
    logic        busy;
    logic [2:0]  fifo_count;

    enigma_display_sequencer_if in_if ();

    enigma_display_sequencer #(
        .NUM_DIGITS   (ND),
        .FIFO_DEPTH   (FD),
        .DWELL_CYCLES (DW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_if        (in_if.slave),
        .clear        (clear),
        .digits_ascii (digits_ascii),
        .update       (update),
        .busy         (busy),
        .fifo_count   (fifo_count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: character queue, shift-register view of digits, last pop time.
    logic [7:0]  q [$];
    logic [31:0] m_dig;
    logic        m_upd;
    logic        m_busy;
    int          edge_n;
    int          last_pop;

    int          cyc;
    int          upd_cyc [$];
    int          max_cnt;
    logic        last_ready;

    typedef struct {
        logic        v;
        logic [7:0]  a;
        logic        c;
        logic [31:0] exp_dig;
        logic        exp_upd;
        logic        exp_busy;
        logic [2:0]  exp_cnt;
    } vec_t;

    vec_t tbl [5];

    function automatic logic [7:0] upcase(input logic [7:0] a);
        return (a >= 8'h61 && a <= 8'h7A) ? (a - 8'h20) : a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_dig    = {ND{8'h20}};
        m_upd    = 1'b0;
        m_busy   = 1'b0;
        last_pop = -1000;
        edge_n   = 0;
    endtask

    task automatic model_edge(input logic v, input logic [7:0] a, input logic c);
        logic       do_pop;
        logic       do_push;
        logic [7:0] head;
        if (c) begin
            q.delete();
            m_dig    = {ND{8'h20}};
            m_upd    = 1'b1;
            last_pop = -1000;
        end else begin
            do_pop  = (q.size() > 0) && (edge_n >= last_pop + int'(DW));
            do_push = v && (q.size() < int'(FD));
            m_upd   = do_pop;
            if (do_pop) begin
                head     = q.pop_front();
                m_dig    = {m_dig[23:0], head};
                last_pop = edge_n;
            end
            if (do_push) q.push_back(upcase(a));
        end
        m_busy = (q.size() > 0) || (edge_n <= last_pop + int'(DW) - 2);
        edge_n++;
    endtask

    // One clock: drive inputs, check ready, advance DUT and model, check outputs.
    task automatic step(input logic v, input logic [7:0] a, input logic c);
        logic exp_ready;
        in_if.in_valid = v;
        in_if.in_ascii = a;
        clear          = c;
        #1;
        exp_ready = (q.size() < int'(FD)) && !c;
        chk("in_ready", 32'(in_if.in_ready), 32'(exp_ready));
        last_ready = in_if.in_ready;
        @(posedge clock);
        model_edge(v, a, c);
        #1;
        cyc++;
        chk("digits",     digits_ascii,      m_dig);
        chk("update",     32'(update),       32'(m_upd));
        chk("busy",       32'(busy),         32'(m_busy));
        chk("fifo_count", 32'(fifo_count),   32'(q.size()));
        if (update) upd_cyc.push_back(cyc);
        if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    endtask

    task automatic push_char(input string name, input logic [7:0] ch);
        int tries = 0;
        do begin
            step(1'b1, ch, 1'b0);
            tries++;
        end while (!last_ready && tries < 20);
        chk(name, 32'(last_ready), 32'd1);
    endtask

    task automatic drain(input int max_steps);
        for (int i = 0; i < max_steps && (busy || fifo_count != 0); i++) step(1'b0, 8'h00, 1'b0);
        chk("drain_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string s3;
        string s4;
        logic [7:0] ch;
        cyc     = 0;
        max_cnt = 0;

        tbl[0] = '{1'b1, 8'h61, 1'b0, 32'h20202020, 1'b0, 1'b1, 3'd1};
        tbl[1] = '{1'b0, 8'h00, 1'b0, 32'h20202041, 1'b1, 1'b1, 3'd0};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 32'h20202041, 1'b0, 1'b1, 3'd0};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 32'h20202041, 1'b0, 1'b1, 3'd0};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 32'h20202041, 1'b0, 1'b0, 3'd0};

        in_if.in_valid = 1'b0;
        in_if.in_ascii = 8'h00;
        clear          = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        model_reset();

        // Reset asserted mid-HOLD with two entries queued.
        step(1'b1, 8'h58, 1'b0);
        step(1'b1, 8'h59, 1'b0);
        step(1'b1, 8'h5A, 1'b0);
        chk("t1_queued", 32'(fifo_count), 32'd2);
        #2 reset = 1'b1;
        #1;
        chk("t1_rst_digits", digits_ascii,      32'h20202020);
        chk("t1_rst_count",  32'(fifo_count),   32'd0);
        chk("t1_rst_busy",   32'(busy),         32'd0);
        chk("t1_rst_update", 32'(update),       32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        model_reset();

        // Single lowercase push: table-driven expectations.
        for (int i = 0; i < 5; i++) begin
            step(tbl[i].v, tbl[i].a, tbl[i].c);
            chk("t2_digits", digits_ascii,      tbl[i].exp_dig);
            chk("t2_update", 32'(update),       32'(tbl[i].exp_upd));
            chk("t2_busy",   32'(busy),         32'(tbl[i].exp_busy));
            chk("t2_count",  32'(fifo_count),   32'(tbl[i].exp_cnt));
        end

        // ABCDE back-to-back: fills at four held, updates spaced by the dwell.
        upd_cyc.delete();
        s3 = "ABCDE";
        for (int i = 0; i < 5; i++) begin
            ch = s3[i];
            push_char("t3_push", ch);
        end
        chk("t3_full_count", 32'(fifo_count), 32'd4);
        drain(60);
        chk("t3_final", digits_ascii, 32'h42434445);
        chk("t3_n_updates", 32'(upd_cyc.size()), 32'd5);
        for (int i = 1; i < upd_cyc.size(); i++)
            chk("t3_gap", 32'(upd_cyc[i] - upd_cyc[i-1]), 32'd4);

        // Full FIFO with a pop in the same cycle: offer refused, accepted next cycle.
        s4 = "GHIJK";
        for (int i = 0; i < 5; i++) begin
            ch = s4[i];
            push_char("t4_push", ch);
        end
        step(1'b1, 8'h4C, 1'b0);
        chk("t4_full_ready", 32'(last_ready), 32'd0);
        chk("t4_after_pop",  32'(fifo_count), 32'd3);
        step(1'b1, 8'h4C, 1'b0);
        chk("t4_ready_next", 32'(last_ready), 32'd1);
        chk("t4_refilled",   32'(fifo_count), 32'd4);
        drain(60);
        chk("t4_max_count", 32'(max_cnt <= 4), 32'd1);

        // clear with in_valid during HOLD and a non-empty FIFO.
        step(1'b1, 8'h4D, 1'b0);
        step(1'b1, 8'h4E, 1'b0);
        step(1'b1, 8'h4F, 1'b0);
        step(1'b1, 8'h50, 1'b1);
        chk("t5_ready",  32'(last_ready),     32'd0);
        chk("t5_digits", digits_ascii,        32'h20202020);
        chk("t5_count",  32'(fifo_count),     32'd0);
        chk("t5_update", 32'(update),         32'd1);
        chk("t5_busy",   32'(busy),           32'd0);
        step(1'b0, 8'h00, 1'b0);
        chk("t5_update_once", 32'(update),    32'd0);
        chk("t5_still_blank", digits_ascii,   32'h20202020);

        // Digit and uppercase codes pass through unchanged.
        step(1'b1, 8'h31, 1'b0);
        step(1'b1, 8'h5A, 1'b0);
        chk("t6_first", digits_ascii, 32'h20202031);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("t6_second",        digits_ascii, 32'h2020315A);
        chk("t6_second_update", 32'(update),  32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic       v;
            logic [7:0] a;
            logic       c;
            v = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(8'h61, 8'h7A)) : 8'($urandom);
            c = ($urandom_range(0, 39) == 0);
            step(v, a, c);
        end
        drain(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
